// File: rtl/neuron_seq.sv
// neuron_seq: layer sequencer that streams 64-bit x/w chunks and a bias from
// synchronous memories into an external processing unit, one ReLU'd result per neuron.
module neuron_seq #(
  parameter int unsigned NCHUNK = 4,
  parameter int unsigned NNEUR  = 4,
  parameter int unsigned AW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] x_addr,
  output logic [AW-1:0] w_addr,
  output logic [AW-1:0] b_addr,
  input  logic [63:0]   x_data,
  input  logic [63:0]   w_data,
  input  logic [7:0]    b_data,
  output logic [63:0]   pu_x,
  output logic [63:0]   pu_w,
  output logic [7:0]    pu_bias,
  output logic          pu_isfirst,
  input  logic [7:0]    pu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic [3:0]    res_idx
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, HOLD} state_e;

  localparam logic [4:0]    LAST_CHUNK   = 5'(NCHUNK);
  localparam logic [3:0]    LAST_NEUR    = 4'(NNEUR - 1);
  localparam logic [AW-1:0] CHUNK_STRIDE = AW'(NCHUNK);

  state_e        state_q, state_d;
  logic [4:0]    chunk_q, chunk_d;
  logic [3:0]    neur_q, neur_d;
  logic          isfirst_q, isfirst_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [3:0]    res_idx_q, res_idx_d;
  logic [AW-1:0] x_addr_q, w_addr_q, b_addr_q;
  logic [AW-1:0] x_addr_d, w_addr_d, b_addr_d;
  logic          last_neur;
  logic          in_run;

  assign last_neur = (neur_q == LAST_NEUR);
  assign in_run    = (state_q == RUN);

  // chunk_q is the chunk address being issued; RUN consumes the chunk issued
  // one cycle earlier, so the last RUN cycle is the one with chunk_q == NCHUNK.
  always_comb begin
    state_d    = state_q;
    chunk_d    = chunk_q;
    neur_d     = neur_q;
    isfirst_d  = 1'b0;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          chunk_d = '0;
          neur_d  = '0;
        end
      end
      FILL: begin
        state_d   = RUN;
        chunk_d   = 5'd1;
        isfirst_d = 1'b1;
      end
      RUN: begin
        if (chunk_q == LAST_CHUNK) begin
          state_d    = HOLD;
          res_data_d = pu_out[7] ? '0 : pu_out;
          res_idx_d  = neur_q;
        end else begin
          chunk_d = chunk_q + 5'd1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          chunk_d = '0;
          if (last_neur) begin
            state_d = IDLE;
            neur_d  = '0;
          end else begin
            state_d = FILL;
            neur_d  = neur_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_addr_d = AW'(chunk_d);
    w_addr_d = AW'(neur_d) * CHUNK_STRIDE + AW'(chunk_d);
    b_addr_d = AW'(neur_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      chunk_q    <= '0;
      neur_q     <= '0;
      isfirst_q  <= 1'b0;
      res_data_q <= '0;
      res_idx_q  <= '0;
      x_addr_q   <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      chunk_q    <= chunk_d;
      neur_q     <= neur_d;
      isfirst_q  <= isfirst_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
      x_addr_q   <= x_addr_d;
      w_addr_q   <= w_addr_d;
      b_addr_q   <= b_addr_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign res_valid  = (state_q == HOLD);
  assign done       = (state_q == HOLD) && res_ready && last_neur;
  assign pu_isfirst = isfirst_q;
  assign res_data   = res_data_q;
  assign res_idx    = res_idx_q;
  assign x_addr     = x_addr_q;
  assign w_addr     = w_addr_q;
  assign b_addr     = b_addr_q;
  assign pu_x       = in_run ? x_data : '0;
  assign pu_w       = in_run ? w_data : '0;
  assign pu_bias    = in_run ? b_data : '0;

endmodule

// File: tb/tb_neuron_seq.sv
// Self-checking bench for neuron_seq: three configurations sharing behavioural
// memories and a lane-0 multiply-accumulate processing-unit stub.
module tb_neuron_seq;
  localparam int NDUT = 3;  // 0: NCHUNK=2,NNEUR=3  1: NCHUNK=1,NNEUR=2  2: NCHUNK=2,NNEUR=1

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start     [NDUT];
  logic        res_ready [NDUT];
  logic        busy      [NDUT];
  logic        done      [NDUT];
  logic        pu_isfirst[NDUT];
  logic        res_valid [NDUT];
  logic [7:0]  x_addr    [NDUT];
  logic [7:0]  w_addr    [NDUT];
  logic [7:0]  b_addr    [NDUT];
  logic [63:0] x_data    [NDUT];
  logic [63:0] w_data    [NDUT];
  logic [63:0] pu_x      [NDUT];
  logic [63:0] pu_w      [NDUT];
  logic [7:0]  b_data    [NDUT];
  logic [7:0]  pu_bias   [NDUT];
  logic [7:0]  pu_out    [NDUT];
  logic [7:0]  acc       [NDUT];
  logic [7:0]  res_data  [NDUT];
  logic [3:0]  res_idx   [NDUT];

  logic [7:0] xm [256];
  logic [7:0] wm [256];
  logic [7:0] bm [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_seq #(.NCHUNK(2), .NNEUR(3), .AW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .x_addr(x_addr[0]), .w_addr(w_addr[0]), .b_addr(b_addr[0]),
    .x_data(x_data[0]), .w_data(w_data[0]), .b_data(b_data[0]),
    .pu_x(pu_x[0]), .pu_w(pu_w[0]), .pu_bias(pu_bias[0]), .pu_isfirst(pu_isfirst[0]),
    .pu_out(pu_out[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_data(res_data[0]), .res_idx(res_idx[0])
  );

  neuron_seq #(.NCHUNK(1), .NNEUR(2), .AW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .x_addr(x_addr[1]), .w_addr(w_addr[1]), .b_addr(b_addr[1]),
    .x_data(x_data[1]), .w_data(w_data[1]), .b_data(b_data[1]),
    .pu_x(pu_x[1]), .pu_w(pu_w[1]), .pu_bias(pu_bias[1]), .pu_isfirst(pu_isfirst[1]),
    .pu_out(pu_out[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_data(res_data[1]), .res_idx(res_idx[1])
  );

  neuron_seq #(.NCHUNK(2), .NNEUR(1), .AW(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .x_addr(x_addr[2]), .w_addr(w_addr[2]), .b_addr(b_addr[2]),
    .x_data(x_data[2]), .w_data(w_data[2]), .b_data(b_data[2]),
    .pu_x(pu_x[2]), .pu_w(pu_w[2]), .pu_bias(pu_bias[2]), .pu_isfirst(pu_isfirst[2]),
    .pu_out(pu_out[2]), .res_valid(res_valid[2]), .res_ready(res_ready[2]),
    .res_data(res_data[2]), .res_idx(res_idx[2])
  );

  // Synchronous-read memories; upper lanes carry a fixed pattern to expose lane mapping.
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      x_data[i] <= {{7{8'hA5}}, xm[x_addr[i]]};
      w_data[i] <= {{7{8'h5A}}, wm[w_addr[i]]};
      b_data[i] <= bm[b_addr[i]];
      acc[i]    <= pu_out[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NDUT; i++) begin
      pu_out[i] = (pu_isfirst[i] ? pu_bias[i] : acc[i]) + 8'(pu_x[i][7:0] * pu_w[i][7:0]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int i, input int n0, output int n);
    n = n0;
    while (res_valid[i] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("res_valid_seen", 64'(res_valid[i]), 64'd1);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] w;
    logic [7:0] b;
    logic [7:0] exp;
  } cvec_t;

  typedef struct {
    logic       busy;
    logic       isf;
    logic       valid;
    logic       dn;
    logic [7:0] waddr;
    logic [7:0] data;
    logic [3:0] idx;
  } bcyc_t;

  cvec_t ctab[5];
  bcyc_t btab[7];
  logic [7:0] aexp[3];

  task automatic run_a(input bit glitch, input bit stall);
    int n;
    res_ready[0] = 1'b0;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    if (glitch) begin
      step();
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      chk("A_busy_after_glitch", 64'(busy[0]), 64'd1);
    end
    for (int k = 0; k < 3; k++) begin
      wait_valid(0, (glitch && k == 0) ? 2 : 0, n);
      chk("A_period", 64'(n + 1), 64'd4);
      chk("A_data", 64'(res_data[0]), 64'(aexp[k]));
      chk("A_idx", 64'(res_idx[0]), 64'(k));
      if (stall && k == 1) begin
        for (int s = 0; s < 5; s++) begin
          step();
          chk("A_stall_valid", 64'(res_valid[0]), 64'd1);
          chk("A_stall_data", 64'(res_data[0]), 64'h16);
          chk("A_stall_idx", 64'(res_idx[0]), 64'd1);
          chk("A_stall_xaddr", 64'(x_addr[0]), 64'd2);
          chk("A_stall_waddr", 64'(w_addr[0]), 64'd4);
          chk("A_stall_baddr", 64'(b_addr[0]), 64'd1);
        end
      end
      res_ready[0] = 1'b1;
      #1;
      chk("A_done", 64'(done[0]), (k == 2) ? 64'd1 : 64'd0);
      step();
      res_ready[0] = 1'b0;
      if (k < 2) begin
        chk("A_fill_valid", 64'(res_valid[0]), 64'd0);
        chk("A_fill_xaddr", 64'(x_addr[0]), 64'd0);
        chk("A_fill_waddr", 64'(w_addr[0]), 64'((k + 1) * 2));
        chk("A_fill_baddr", 64'(b_addr[0]), 64'(k + 1));
      end else begin
        chk("A_end_busy", 64'(busy[0]), 64'd0);
        chk("A_end_done", 64'(done[0]), 64'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ctab[0] = '{8'h03, 8'h02, 8'h01, 8'h0D};
    ctab[1] = '{8'h00, 8'h00, 8'hF0, 8'h00};
    ctab[2] = '{8'h05, 8'h05, 8'h10, 8'h42};
    ctab[3] = '{8'h7F, 8'h01, 8'h7F, 8'h7D};
    ctab[4] = '{8'h01, 8'h01, 8'h7E, 8'h00};

    btab[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0};
    btab[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 4'h0};
    btab[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h0D, 4'h0};
    btab[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h0D, 4'h0};
    btab[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h0D, 4'h0};
    btab[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 8'h0E, 4'h1};
    btab[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0E, 4'h1};

    aexp[0] = 8'h03;
    aexp[1] = 8'h16;
    aexp[2] = 8'h29;

    for (int i = 0; i < 256; i++) begin
      xm[i] = 8'h00;
      wm[i] = 8'h00;
      bm[i] = 8'h00;
    end
    for (int i = 0; i < NDUT; i++) begin
      start[i]     = 1'b0;
      res_ready[i] = 1'b0;
    end

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_valid", 64'(res_valid[i]), 64'd0);
      chk("rst_isfirst", 64'(pu_isfirst[i]), 64'd0);
      chk("rst_data", 64'(res_data[i]), 64'd0);
      chk("rst_waddr", 64'(w_addr[i]), 64'd0);
    end
    rst_n = 1'b1;
    step();

    // Single-neuron layers, table of operand/bias sets.
    res_ready[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      xm[0] = ctab[k].x;
      xm[1] = ctab[k].x;
      wm[0] = ctab[k].w;
      wm[1] = ctab[k].w;
      bm[0] = ctab[k].b;
      start[2] = 1'b1;
      step();
      start[2] = 1'b0;
      wait_valid(2, 0, n);
      chk("C_latency", 64'(n + 1), 64'd4);
      chk("C_data", 64'(res_data[2]), 64'(ctab[k].exp));
      chk("C_idx", 64'(res_idx[2]), 64'd0);
      chk("C_done", 64'(done[2]), 64'd1);
      chk("C_pux_hold", pu_x[2], 64'd0);
      step();
      chk("C_idle_busy", 64'(busy[2]), 64'd0);
      chk("C_idle_done", 64'(done[2]), 64'd0);
    end
    res_ready[2] = 1'b0;

    // NCHUNK=1, NNEUR=2: cycle-by-cycle expectations.
    xm[0] = 8'h03;
    wm[0] = 8'h04;
    wm[1] = 8'h05;
    bm[0] = 8'h01;
    bm[1] = 8'hFF;
    res_ready[1] = 1'b1;
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk("B_busy", 64'(busy[1]), 64'(btab[c].busy));
      chk("B_isfirst", 64'(pu_isfirst[1]), 64'(btab[c].isf));
      chk("B_valid", 64'(res_valid[1]), 64'(btab[c].valid));
      chk("B_done", 64'(done[1]), 64'(btab[c].dn));
      chk("B_waddr", 64'(w_addr[1]), 64'(btab[c].waddr));
      chk("B_data", 64'(res_data[1]), 64'(btab[c].data));
      chk("B_idx", 64'(res_idx[1]), 64'(btab[c].idx));
      chk("B_pux", pu_x[1], btab[c].isf ? {{7{8'hA5}}, 8'h03} : 64'd0);
      step();
    end
    res_ready[1] = 1'b0;

    // Three neurons, backpressure on neuron 1, then a re-run with a start glitch.
    xm[0] = 8'h01;
    xm[1] = 8'h02;
    wm[0] = 8'h01; wm[1] = 8'h01;
    wm[2] = 8'h02; wm[3] = 8'h02;
    wm[4] = 8'h03; wm[5] = 8'h03;
    bm[0] = 8'h00;
    bm[1] = 8'h10;
    bm[2] = 8'h20;
    run_a(1'b0, 1'b1);
    step();
    run_a(1'b1, 1'b0);
    step();

    // Asynchronous reset in the first RUN cycle of neuron 1, then restart.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_valid(0, 0, n);
    res_ready[0] = 1'b1;
    step();
    res_ready[0] = 1'b0;
    step();
    chk("R_in_run", 64'(pu_isfirst[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("R_busy", 64'(busy[0]), 64'd0);
    chk("R_done", 64'(done[0]), 64'd0);
    chk("R_valid", 64'(res_valid[0]), 64'd0);
    chk("R_isfirst", 64'(pu_isfirst[0]), 64'd0);
    chk("R_data", 64'(res_data[0]), 64'd0);
    chk("R_idx", 64'(res_idx[0]), 64'd0);
    chk("R_xaddr", 64'(x_addr[0]), 64'd0);
    chk("R_waddr", 64'(w_addr[0]), 64'd0);
    chk("R_baddr", 64'(b_addr[0]), 64'd0);
    chk("R_pux", pu_x[0], 64'd0);
    chk("R_puw", pu_w[0], 64'd0);
    chk("R_pubias", 64'(pu_bias[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start[0] = 1'b1;
    res_ready[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("R2_busy", 64'(busy[0]), 64'd1);
    chk("R2_waddr", 64'(w_addr[0]), 64'd0);
    chk("R2_baddr", 64'(b_addr[0]), 64'd0);
    chk("R2_xaddr", 64'(x_addr[0]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      wait_valid(0, 0, n);
      chk("R2_period", 64'(n + 1), 64'd4);
      chk("R2_data", 64'(res_data[0]), 64'(aexp[k]));
      chk("R2_idx", 64'(res_idx[0]), 64'(k));
      chk("R2_done", 64'(done[0]), (k == 2) ? 64'd1 : 64'd0);
      step();
    end
    chk("R2_end_busy", 64'(busy[0]), 64'd0);
    res_ready[0] = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
